// File: rtl/bus_arbiter_fsm.sv
// Round-robin transaction arbiter with per-owner lock and a one-cycle bus turnaround.
// Optional watchdog forced release is compiled in when ARB_TIMEOUT_EN is defined.
module bus_arbiter_fsm #(
  parameter int unsigned N       = 8,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ce,
  input  logic [N-1:0]       req,
  input  logic [N-1:0]       lock,
  input  logic               done,
  output logic [N-1:0]       gnt,
  output logic [$clog2(N):0] gnt_enc,
  output logic               gnt_vld,
  output logic               timeout
);

  localparam int unsigned PW = $clog2(N);

  if (N < 2 || N > 32) begin : g_n_check
    $error("bus_arbiter_fsm: N must be within 2..32");
  end
  if (TIMEOUT < 2) begin : g_timeout_check
    $error("bus_arbiter_fsm: TIMEOUT must be at least 2");
  end

  typedef enum logic [1:0] {StIdle, StBusy, StTurn} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [PW:0]   enc_q, enc_d;
  logic          vld_q, vld_d;

  logic          win_vld;
  logic [PW-1:0] win_idx;
  logic          owner_req;
  logic          owner_keep;
  logic          wd_expire;

  // Scan from the highest index down so the last hit is the first one at or after ptr.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[(int'(ptr_q) + i) % int'(N)]) begin
        win_vld = 1'b1;
        win_idx = PW'((int'(ptr_q) + i) % int'(N));
      end
    end
  end

  assign owner_req  = |(req & gnt_q);
  assign owner_keep = |(req & lock & gnt_q);

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned WW = $clog2(TIMEOUT + 1);

  logic [WW-1:0] wd_q, wd_d;
  logic          timeout_q;

  // Fires on the counted BUSY cycle that brings the count to TIMEOUT.
  assign wd_expire = (state_q == StBusy) && !done && (wd_q == WW'(TIMEOUT - 1));

  always_comb begin
    wd_d = '0;
    if (state_q == StBusy && state_d == StBusy && !done) begin
      wd_d = wd_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else if (ce) begin
      wd_q      <= wd_d;
      timeout_q <= wd_expire;
    end
  end

  assign timeout = timeout_q;
`else
  assign wd_expire = 1'b0;
  assign timeout   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      gnt_q   <= '0;
      enc_q   <= '1;
      vld_q   <= 1'b0;
    end else if (ce) begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      enc_q   <= enc_d;
      vld_q   <= vld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      StIdle, StTurn: begin
        if (win_vld) begin
          state_d = StBusy;
          ptr_d   = (win_idx == PW'(N - 1)) ? '0 : win_idx + 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      StBusy: begin
        if (wd_expire) begin
          state_d = StTurn;
        end else if (done) begin
          state_d = owner_keep ? StBusy : StTurn;
        end else if (!owner_req) begin
          state_d = StTurn;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    gnt_d = gnt_q;
    enc_d = enc_q;
    if (state_d != StBusy) begin
      gnt_d = '0;
      enc_d = '1;
    end else if (state_q != StBusy) begin
      gnt_d = {{(N - 1){1'b0}}, 1'b1} << win_idx;
      enc_d = {1'b0, win_idx};
    end
    vld_d = (state_d == StBusy);
  end

  assign gnt     = gnt_q;
  assign gnt_enc = enc_q;
  assign gnt_vld = vld_q;

endmodule

// File: tb/tb_bus_arbiter_fsm.sv
// Directed bench for bus_arbiter_fsm with N=4, TIMEOUT=8.
// The watchdog section runs only when ARB_TIMEOUT_EN is defined.
module tb_bus_arbiter_fsm;

  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ce;
  logic [N-1:0] req;
  logic [N-1:0] lock;
  logic         done;
  logic [N-1:0] gnt;
  logic [2:0]   gnt_enc;
  logic         gnt_vld;
  logic         timeout;

  int total = 0;
  int bad   = 0;

  bus_arbiter_fsm #(
    .N      (N),
    .TIMEOUT(8)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ce     (ce),
    .req    (req),
    .lock   (lock),
    .done   (done),
    .gnt    (gnt),
    .gnt_enc(gnt_enc),
    .gnt_vld(gnt_vld),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Grant vector, encoding and valid are all implied by the expected owner (-1 = none).
  task automatic chk_own(input string tag, input int owner, input logic exp_to);
    logic [N-1:0] eg;
    logic [2:0]   ee;
    eg = '0;
    ee = 3'b111;
    if (owner >= 0) begin
      eg[owner] = 1'b1;
      ee        = 3'(owner);
    end
    chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
    chk({tag, ".enc"}, 32'(gnt_enc), 32'(ee));
    chk({tag, ".vld"}, 32'(gnt_vld), 32'(owner >= 0));
    chk({tag, ".timeout"}, 32'(timeout), 32'(exp_to));
  endtask

  initial begin
    #100000;
    $display("FAIL global_time_limit observed=running expected=finished");
    $fatal(1, "time limit");
  end

  initial begin
    int order [5];
    order = '{3, 0, 1, 2, 3};

    rst_n = 1'b0;
    ce    = 1'b1;
    req   = '0;
    lock  = '0;
    done  = 1'b0;
    #12;
    chk_own("reset", -1, 1'b0);
    rst_n = 1'b1;
    tick();
    chk_own("idle_no_req", -1, 1'b0);

    // Basic grant from IDLE, done, TURN, next owner.
    req = 4'b0110;
    tick();
    chk_own("first_grant", 1, 1'b0);
    tick();
    chk_own("first_hold", 1, 1'b0);
    done = 1'b1;
    tick();
    chk_own("done_turn", -1, 1'b0);
    done = 1'b0;
    tick();
    chk_own("second_grant", 2, 1'b0);
    done = 1'b1;
    tick();
    chk_own("second_turn", -1, 1'b0);
    done = 1'b0;
    req  = '0;
    tick();
    chk_own("back_idle", -1, 1'b0);

    // All requesting; ptr is 3 here so rotation starts at 3.
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_own($sformatf("rr%0d_grant", k), order[k], 1'b0);
      tick();
      chk_own($sformatf("rr%0d_b2", k), order[k], 1'b0);
      tick();
      chk_own($sformatf("rr%0d_b3", k), order[k], 1'b0);
      done = 1'b1;
      tick();
      chk_own($sformatf("rr%0d_turn", k), -1, 1'b0);
      done = 1'b0;
    end
    req = '0;
    tick();
    chk_own("rr_idle", -1, 1'b0);

    // Locked owner 2 keeps the bus across done pulses; 3 waits.
    req  = 4'b1100;
    lock = 4'b0100;
    tick();
    chk_own("lock_grant", 2, 1'b0);
    done = 1'b1;
    tick();
    chk_own("lock_done1", 2, 1'b0);
    tick();
    chk_own("lock_done2", 2, 1'b0);
    done = 1'b0;
    tick();
    chk_own("lock_hold", 2, 1'b0);
    lock = '0;
    done = 1'b1;
    tick();
    chk_own("unlock_turn", -1, 1'b0);
    done = 1'b0;
    tick();
    chk_own("after_lock_owner3", 3, 1'b0);

    // Abort: owner drops req without done.
    req = '0;
    tick();
    chk_own("abort3_turn", -1, 1'b0);
    tick();
    chk_own("abort3_idle", -1, 1'b0);
    req = 4'b0110;
    tick();
    chk_own("abort_grant1", 1, 1'b0);
    tick();
    chk_own("abort_hold1", 1, 1'b0);
    req = 4'b0100;
    tick();
    chk_own("abort1_turn", -1, 1'b0);
    tick();
    chk_own("abort_next2", 2, 1'b0);
    done = 1'b1;
    tick();
    chk_own("abort_done_turn", -1, 1'b0);
    req = '0;
    tick();
    chk_own("done_in_idle", -1, 1'b0);
    tick();
    chk_own("done_in_idle2", -1, 1'b0);
    done = 1'b0;
    req  = 4'b0001;
    tick();
    chk_own("wrap_grant0", 0, 1'b0);

    // Clock enable freezes everything.
    ce   = 1'b0;
    done = 1'b1;
    tick();
    chk_own("ce_low_busy", 0, 1'b0);
    ce = 1'b1;
    tick();
    chk_own("ce_high_done", -1, 1'b0);
    done = 1'b0;
    req  = '0;
    tick();
    chk_own("ce_idle", -1, 1'b0);
    ce  = 1'b0;
    req = 4'b0010;
    tick();
    chk_own("ce_low_idle1", -1, 1'b0);
    tick();
    chk_own("ce_low_idle2", -1, 1'b0);
    ce = 1'b1;
    tick();
    chk_own("ce_resume_grant", 1, 1'b0);

    // Asynchronous reset between edges, then ptr must restart at 0.
    #2;
    rst_n = 1'b0;
    #1;
    chk_own("async_reset", -1, 1'b0);
    #1;
    rst_n = 1'b1;
    req   = 4'b1010;
    tick();
    chk_own("post_reset_grant", 1, 1'b0);

`ifdef ARB_TIMEOUT_EN
    for (int k = 0; k < 7; k++) begin
      tick();
      chk_own($sformatf("wd_hold%0d", k), 1, 1'b0);
    end
    tick();
    chk_own("wd_fire", -1, 1'b1);
    tick();
    chk_own("wd_next_owner", 3, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_own($sformatf("wd2_pre%0d", k), 3, 1'b0);
    end
    ce = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_own($sformatf("wd2_frozen%0d", k), 3, 1'b0);
    end
    ce = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_own($sformatf("wd2_post%0d", k), 3, 1'b0);
    end
    tick();
    chk_own("wd2_fire", -1, 1'b1);
`else
    done = 1'b1;
    tick();
    chk_own("final_turn", -1, 1'b0);
    done = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
